alu_issuer: RTL and testbench

Initiator-side front end for the `Alu` block: accepts tagged ALU requests over a valid/ready handshake and drives the Alu `en`/`op`/`operand0`/`operand1` ports. It captures `res`/`zero`/`neg` after the Alu's one-cycle registered latency and returns in-order tagged responses under backpressure. It also screens out reserved opcodes and divide-by-zero so the Alu never sees them. Sits between the instruction decode/execute control and the Alu instance.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issuer_if.sv | 47 ++++
 rtl/alu_resp_fifo.sv | 55 +++++
 rtl/alu_issuer.sv | 146 ++++++++++++++
 tb/tb_alu_issuer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Alu opcode map, reserved-opcode screen and the response record queued by the issuer.
package alu_pkg;

   localparam logic [3:0] ADD = 4'b0000;
   localparam logic [3:0] SUB = 4'b0001;
   localparam logic [3:0] MUL = 4'b0010;
   localparam logic [3:0] DIV = 4'b0011;
   localparam logic [3:0] NOT = 4'b1000;
   localparam logic [3:0] AND = 4'b1001;
   localparam logic [3:0] OR  = 4'b1010;
   localparam logic [3:0] XOR = 4'b1011;
   localparam logic [3:0] LSL = 4'b1100;
   localparam logic [3:0] LSR = 4'b1101;
   localparam logic [3:0] ASL = 4'b1110;
   localparam logic [3:0] ASR = 4'b1111;

   // Width of the tag field carried inside the queued response record.
   localparam int RESP_TAG_W = 4;

   typedef struct packed {
      logic [31:0]           res;
      logic                  zero;
      logic                  neg;
      logic                  err;
      logic [RESP_TAG_W-1:0] tag;
   } alu_resp_t;

   // 4'b0100..4'b0111 have no Alu function behind them.
   function automatic logic is_reserved_op(input logic [3:0] op);
      return op[3:2] == 2'b01;
   endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Request, Alu-port and response bundle of the Alu issuer; slave is the issuer side,
// master is the requester/consumer/Alu environment side.
interface alu_issuer_if #(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;

   logic             alu_en;
   logic [3:0]       alu_op;
   logic [31:0]      alu_operand0;
   logic [31:0]      alu_operand1;
   logic [31:0]      alu_res;
   logic             alu_zero;
   logic             alu_neg;

   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_res;
   logic             resp_zero;
   logic             resp_neg;
   logic             resp_err;
   logic [TAG_W-1:0] resp_tag;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag,
      output req_ready,
      output alu_en, alu_op, alu_operand0, alu_operand1,
      input  alu_res, alu_zero, alu_neg,
      output resp_valid, resp_res, resp_zero, resp_neg, resp_err, resp_tag,
      input  resp_ready
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag,
      input  req_ready,
      input  alu_en, alu_op, alu_operand0, alu_operand1,
      output alu_res, alu_zero, alu_neg,
      input  resp_valid, resp_res, resp_zero, resp_neg, resp_err, resp_tag,
      output resp_ready
   );

endinterface

// File: rtl/alu_resp_fifo.sv
// First-word-fall-through FIFO with occupancy count; head visible the cycle after the write.
// No internal backpressure: caller must never push when full without a same-cycle pop.
module alu_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     wr_dat,
   input  logic             pop,
   output logic             rd_vld,
   output logic [W-1:0]     rd_dat,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_en;

   assign rd_vld = (count != '0);
   assign rd_dat = mem[rd_ptr];
   assign pop_en = pop && rd_vld;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

endmodule

// File: rtl/alu_issuer.sv
// Alu issue front end: screens reserved ops and divide-by-zero, returns tagged in-order responses.
// Accept-to-response latency 3 cycles; req_ready drops once in-flight plus queued entries reach DEPTH.
module alu_issuer
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input logic         clk,
   input logic         rst,
   alu_issuer_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;

   logic             accept;
   logic             req_rsvd;
   logic             req_div0;
   logic             req_byp;

   logic             s1_v;
   logic             s1_byp;
   logic             s1_err;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_v;
   logic             s2_byp;
   logic             s2_err;
   logic [TAG_W-1:0] s2_tag;

   logic             alu_en_q;
   logic [3:0]       alu_op_q;
   logic [31:0]      alu_a_q;
   logic [31:0]      alu_b_q;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_vld;
   logic             fifo_pop;
   logic [SUM_W-1:0] in_flight;
   alu_resp_t        wr_rec;
   alu_resp_t        head;

   // Every accepted request holds a FIFO slot from acceptance until popped,
   // so the S1->S2->FIFO path can never find the queue full.
   assign in_flight     = SUM_W'(s1_v) + SUM_W'(s2_v) + SUM_W'(fifo_count);
   assign bus.req_ready = in_flight < SUM_W'(DEPTH);
   assign accept        = bus.req_valid && bus.req_ready;

   assign req_rsvd = is_reserved_op(bus.req_op);
   assign req_div0 = (bus.req_op == DIV) && (bus.req_b == '0);
   assign req_byp  = req_rsvd || req_div0;

   // Bypassed slots leave the Alu ports untouched and en low.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s1_byp   <= 1'b0;
         s1_err   <= 1'b0;
         s1_tag   <= '0;
         alu_en_q <= 1'b0;
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
      end else begin
         s1_v     <= accept;
         alu_en_q <= accept && !req_byp;
         if (accept) begin
            s1_tag <= bus.req_tag;
            s1_byp <= req_byp;
            s1_err <= req_rsvd;
         end
         if (accept && !req_byp) begin
            alu_op_q <= bus.req_op;
            alu_a_q  <= bus.req_a;
            alu_b_q  <= bus.req_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v   <= 1'b0;
         s2_byp <= 1'b0;
         s2_err <= 1'b0;
         s2_tag <= '0;
      end else begin
         s2_v   <= s1_v;
         s2_byp <= s1_byp;
         s2_err <= s1_err;
         s2_tag <= s1_tag;
      end
   end

   assign bus.alu_en       = alu_en_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.alu_operand0 = alu_a_q;
   assign bus.alu_operand1 = alu_b_q;

   // S2 lines up with the Alu's registered output; err alone tells reserved from div-by-zero.
   always_comb begin
      wr_rec     = '0;
      wr_rec.tag = RESP_TAG_W'(s2_tag);
      if (!s2_byp) begin
         wr_rec.res  = bus.alu_res;
         wr_rec.zero = bus.alu_zero;
         wr_rec.neg  = bus.alu_neg;
         wr_rec.err  = 1'b0;
      end else if (s2_err) begin
         wr_rec.res  = 32'h0000_0000;
         wr_rec.zero = 1'b1;
         wr_rec.neg  = 1'b0;
         wr_rec.err  = 1'b1;
      end else begin
         wr_rec.res  = 32'hFFFF_FFFF;
         wr_rec.zero = 1'b0;
         wr_rec.neg  = 1'b1;
         wr_rec.err  = 1'b0;
      end
   end

   alu_resp_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(alu_resp_t))
   ) u_resp_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (s2_v),
      .wr_dat (wr_rec),
      .pop    (fifo_pop),
      .rd_vld (fifo_vld),
      .rd_dat (head),
      .count  (fifo_count)
   );

   assign fifo_pop = fifo_vld && bus.resp_ready;

   // Data is forced to zero while empty so stale storage never shows on the outputs.
   assign bus.resp_valid = fifo_vld;
   assign bus.resp_res   = fifo_vld ? head.res : '0;
   assign bus.resp_zero  = fifo_vld && head.zero;
   assign bus.resp_neg   = fifo_vld && head.neg;
   assign bus.resp_err   = fifo_vld && head.err;
   assign bus.resp_tag   = fifo_vld ? TAG_W'(head.tag) : '0;

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer with a registered Alu stand-in and a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_issuer;
   import alu_pkg::*;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_issuer_if #(.TAG_W(TAG_W)) bus ();

   alu_issuer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0]      res;
      logic             zero;
      logic             neg;
      logic             err;
      logic [TAG_W-1:0] tag;
      int               due;
   } exp_t;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         MUL:     return a * b;
         DIV:     return (b == 0) ? 32'hFFFF_FFFF : a / b;
         NOT:     return ~a;
         AND:     return a & b;
         OR:      return a | b;
         XOR:     return a ^ b;
         LSL:     return a << b[4:0];
         LSR:     return a >> b[4:0];
         ASL:     return a <<< b[4:0];
         ASR:     return $signed(a) >>> b[4:0];
         default: return 32'h0;
      endcase
   endfunction

   // Alu stand-in: one-cycle registered result while en is high.
   logic [31:0] alu_next;
   assign alu_next = alu_fn(bus.alu_op, bus.alu_operand0, bus.alu_operand1);
   always @(posedge clk) begin
      if (rst) begin
         bus.alu_res  <= 32'h0;
         bus.alu_zero <= 1'b0;
         bus.alu_neg  <= 1'b0;
      end else if (bus.alu_en) begin
         bus.alu_res  <= alu_next;
         bus.alu_zero <= (alu_next == 32'h0);
         bus.alu_neg  <= alu_next[31];
      end
   end

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] tag);
      exp_t e;
      logic [31:0] r;
      e.tag = tag;
      e.due = 0;
      if (op >= 4 && op <= 7) begin
         e.res = 32'h0; e.zero = 1'b1; e.neg = 1'b0; e.err = 1'b1;
      end else if (op == DIV && b == 0) begin
         e.res = 32'hFFFF_FFFF; e.zero = 1'b0; e.neg = 1'b1; e.err = 1'b0;
      end else begin
         r = alu_fn(op, a, b);
         e.res = r; e.zero = (r == 0); e.neg = r[31]; e.err = 1'b0;
      end
      return e;
   endfunction

   task automatic set_req(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = tag;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
      checks++; if (bus.alu_en !== 1'b0) begin errors++; $display("FAIL reset_alu_en got %0b want 0", bus.alu_en); end
      checks++; if (bus.alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_op got %h want 0", bus.alu_op); end
      checks++; if (bus.alu_operand0 !== 32'h0 || bus.alu_operand1 !== 32'h0) begin
         errors++; $display("FAIL reset_alu_operands got %h %h want 0 0", bus.alu_operand0, bus.alu_operand1); end
      checks++; if (bus.resp_res !== 32'h0 || bus.resp_tag !== '0 || bus.resp_err !== 1'b0) begin
         errors++; $display("FAIL reset_resp_data got res %h tag %h err %0b want 0", bus.resp_res, bus.resp_tag, bus.resp_err); end
   endtask

   task automatic test_add_latency();
      bus.resp_ready = 1'b1;
      set_req(1'b1, ADD, 32'h1, 32'hFFFF_FFFF, 4'd3);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL add_req_ready got %0b want 1", bus.req_ready); end
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      checks++; if (bus.alu_en !== 1'b1 || bus.alu_op !== ADD || bus.alu_operand0 !== 32'h1 || bus.alu_operand1 !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL add_alu_ports got en %0b op %h a %h b %h want 1 0 1 ffffffff",
                            bus.alu_en, bus.alu_op, bus.alu_operand0, bus.alu_operand1); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_early_t1 got %0b want 0", bus.resp_valid); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_early_t2 got %0b want 0", bus.resp_valid); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_res !== 32'h0 || bus.resp_zero !== 1'b1 || bus.resp_neg !== 1'b0 ||
                    bus.resp_err !== 1'b0 || bus.resp_tag !== 4'd3) begin
         errors++; $display("FAIL add_resp got v %0b res %h z %0b n %0b e %0b tag %0d want 1 0 1 0 0 3", bus.resp_valid,
                            bus.resp_res, bus.resp_zero, bus.resp_neg, bus.resp_err, bus.resp_tag); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_after_pop got %0b want 0", bus.resp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops     [3] = '{SUB, MUL, LSR};
      logic [31:0] as      [3] = '{32'h1, 32'h2, 32'hFFFF_FFFF};
      logic [31:0] bs      [3] = '{32'h2, 32'h1, 32'h1};
      logic [31:0] exp_res [3] = '{32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF};
      logic        exp_neg [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, ops[i], as[i], bs[i], TAG_W'(i + 8));
         @(negedge clk);
      end
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_res !== exp_res[i] || bus.resp_neg !== exp_neg[i] ||
                       bus.resp_tag !== TAG_W'(i + 8)) begin
            errors++; $display("FAIL b2b_resp%0d got v %0b res %h n %0b tag %0d want 1 %h %0b %0d", i, bus.resp_valid,
                               bus.resp_res, bus.resp_neg, bus.resp_tag, exp_res[i], exp_neg[i], i + 8); end
         @(negedge clk);
      end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b want 0", bus.resp_valid); end
   endtask

   task automatic test_bypass();
      set_req(1'b1, DIV, 32'h2, 32'h0, 4'd5);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      checks++; if (bus.alu_en !== 1'b0 || bus.alu_op !== LSR || bus.alu_operand0 !== 32'hFFFF_FFFF || bus.alu_operand1 !== 32'h1) begin
         errors++; $display("FAIL div0_alu_hold got en %0b op %h a %h b %h want 0 d ffffffff 1",
                            bus.alu_en, bus.alu_op, bus.alu_operand0, bus.alu_operand1); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_res !== 32'hFFFF_FFFF || bus.resp_zero !== 1'b0 || bus.resp_neg !== 1'b1 ||
                    bus.resp_err !== 1'b0 || bus.resp_tag !== 4'd5) begin
         errors++; $display("FAIL div0_resp got v %0b res %h z %0b n %0b e %0b tag %0d want 1 ffffffff 0 1 0 5", bus.resp_valid,
                            bus.resp_res, bus.resp_zero, bus.resp_neg, bus.resp_err, bus.resp_tag); end
      set_req(1'b1, 4'b0101, $urandom, $urandom, 4'd6);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      checks++; if (bus.alu_en !== 1'b0) begin errors++; $display("FAIL rsvd_alu_en got %0b want 0", bus.alu_en); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_res !== 32'h0 || bus.resp_zero !== 1'b1 || bus.resp_neg !== 1'b0 ||
                    bus.resp_err !== 1'b1 || bus.resp_tag !== 4'd6) begin
         errors++; $display("FAIL rsvd_resp got v %0b res %h z %0b n %0b e %0b tag %0d want 1 0 1 0 1 6", bus.resp_valid,
                            bus.resp_res, bus.resp_zero, bus.resp_neg, bus.resp_err, bus.resp_tag); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      exp_t        q[$];
      exp_t        e;
      logic [31:0] as [6];
      logic [31:0] bs [6];
      int          sent = 0;
      int          got = 0;
      for (int i = 0; i < 6; i++) begin as[i] = $urandom; bs[i] = $urandom; end
      bus.resp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (sent < 6) set_req(1'b1, ADD, as[sent], bs[sent], TAG_W'(sent));
         else          set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
         if (bus.req_valid && bus.req_ready) begin q.push_back(model(ADD, as[sent], bs[sent], TAG_W'(sent))); sent++; end
         @(negedge clk);
      end
      checks++; if (sent != DEPTH || bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL bp_credit_stall got accepted %0d ready %0b want 4 0", sent, bus.req_ready); end
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (sent < 6) set_req(1'b1, ADD, as[sent], bs[sent], TAG_W'(sent));
         else          set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
         if (bus.resp_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL bp_spurious got tag %0d want no response", bus.resp_tag);
            end else begin
               e = q.pop_front();
               if (bus.resp_res !== e.res || bus.resp_tag !== e.tag) begin
                  errors++; $display("FAIL bp_order got res %h tag %0d want %h %0d", bus.resp_res, bus.resp_tag, e.res, e.tag); end
            end
            got++;
         end
         if (bus.req_valid && bus.req_ready) begin q.push_back(model(ADD, as[sent], bs[sent], TAG_W'(sent))); sent++; end
         @(negedge clk);
      end
      checks++; if (got != 6 || sent != 6) begin errors++; $display("FAIL bp_drain got resp %0d sent %0d want 6 6", got, sent); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", bus.resp_valid); end
   endtask

   task automatic test_reset_mid();
      bus.resp_ready = 1'b1;
      set_req(1'b1, ADD, 32'd5, 32'd6, 4'd1);
      @(negedge clk);
      set_req(1'b1, SUB, 32'd7, 32'd3, 4'd2);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || bus.alu_en !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_state got v %0b en %0b rdy %0b want 0 0 1", bus.resp_valid, bus.alu_en, bus.req_ready); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost cycle %0d got %0b want 0", c, bus.resp_valid); end
      end
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        e;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp_vld;
      int          sent = 0;
      for (int c = 0; c < 20000 && (sent < 1000 || q.size() > 0); c++) begin
         if (sent < 1000 && $urandom_range(0, 9) < 7) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            set_req(1'b1, op, a, b, TAG_W'(sent));
         end else begin
            set_req(1'b0, 4'h0, 32'h0, 32'h0, '0);
         end
         bus.resp_ready = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
         checks++; if (bus.req_ready !== (q.size() < DEPTH)) begin
            errors++; $display("FAIL rnd_credit cycle %0d got %0b want %0b", c, bus.req_ready, q.size() < DEPTH); end
         exp_vld = (q.size() > 0) && (q[0].due <= c);
         checks++; if (bus.resp_valid !== exp_vld) begin
            errors++; $display("FAIL rnd_valid cycle %0d got %0b want %0b", c, bus.resp_valid, exp_vld); end
         if (bus.resp_valid && bus.resp_ready && q.size() > 0) begin
            e = q.pop_front();
            checks++; if (bus.resp_res !== e.res || bus.resp_zero !== e.zero || bus.resp_neg !== e.neg ||
                          bus.resp_err !== e.err || bus.resp_tag !== e.tag) begin
               errors++; $display("FAIL rnd_resp cycle %0d got res %h z %0b n %0b e %0b tag %0d want %h %0b %0b %0b %0d", c,
                                  bus.resp_res, bus.resp_zero, bus.resp_neg, bus.resp_err, bus.resp_tag,
                                  e.res, e.zero, e.neg, e.err, e.tag); end
         end
         if (bus.req_valid && bus.req_ready) begin
            e = model(bus.req_op, bus.req_a, bus.req_b, bus.req_tag);
            e.due = c + 3;
            q.push_back(e);
            sent++;
         end
         if (bus.alu_en) begin
            checks++; if ((bus.alu_op >= 4 && bus.alu_op <= 7) || (bus.alu_op == DIV && bus.alu_operand1 == 0)) begin
               errors++; $display("FAIL rnd_alu_screen got op %h b %h want no screened op", bus.alu_op, bus.alu_operand1); end
         end
         @(negedge clk);
      end
      checks++; if (sent != 1000 || q.size() != 0) begin
         errors++; $display("FAIL rnd_complete got sent %0d pending %0d want 1000 0", sent, q.size()); end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_back_to_back();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
